// File: rtl/reg_f_ctx.sv
// Register file (R0=0, R1=all ones, ACC at 2, work regs above) with a DEPTH-frame context stack.
// Push/pop each take N=NREG-2 busy cycles; writes and stack requests made while busy are dropped.
module reg_f_ctx #(
    parameter int WIDTH = 8,
    parameter int NREG  = 11,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(NREG),
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rf_addr_r1,
    output logic [WIDTH-1:0] rf_data_out1,
    input  logic [AW-1:0]    rf_addr_r2,
    output logic [WIDTH-1:0] rf_data_out2,
    input  logic [AW-1:0]    rf_addr_wr,
    input  logic             rf_data_we,
    input  logic [WIDTH-1:0] rf_data_in,
    input  logic             rf_stack_push,
    input  logic             rf_stack_pop,
    output logic             rf_busy,
    output logic [DW-1:0]    rf_depth,
    output logic             rf_stack_ovf,
    output logic             rf_stack_unf,
    output logic             rf_acc_zero
);
    localparam int N  = NREG - 2;
    localparam int KW = $clog2(N);
    localparam int FW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_RESTORE} state_t;

    state_t           r_state, w_state_nxt;
    logic [KW-1:0]    r_k, w_k_nxt;
    logic [DW-1:0]    r_depth, w_depth_nxt;
    logic             r_ovf, r_unf, w_ovf_nxt, w_unf_nxt;
    logic [WIDTH-1:0] r_regs [N];
    logic [WIDTH-1:0] r_mem [DEPTH][N];
    logic [FW-1:0]    w_frame;
    logic             w_last;
    logic [WIDTH-1:0] w_rd1, w_rd2;

    assign w_last  = (r_k == KW'(N - 1));
    // SAVE writes the frame above the top; RESTORE reads the top frame
    assign w_frame = (r_state == ST_RESTORE) ? FW'(r_depth - DW'(1)) : FW'(r_depth);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_depth_nxt = r_depth;
        w_ovf_nxt   = 1'b0;
        w_unf_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rf_stack_push) begin
                    if (r_depth < DW'(DEPTH)) begin
                        w_state_nxt = ST_SAVE;
                        w_k_nxt     = '0;
                    end else begin
                        w_ovf_nxt = 1'b1;
                    end
                end else if (rf_stack_pop) begin
                    if (r_depth != '0) begin
                        w_state_nxt = ST_RESTORE;
                        w_k_nxt     = '0;
                    end else begin
                        w_unf_nxt = 1'b1;
                    end
                end
            end
            ST_SAVE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                    w_depth_nxt = r_depth + DW'(1);
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            ST_RESTORE: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_k_nxt     = '0;
                    w_depth_nxt = r_depth - DW'(1);
                end else begin
                    w_k_nxt = r_k + KW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rf_busy      = (r_state != ST_IDLE);
        rf_depth     = r_depth;
        rf_stack_ovf = r_ovf;
        rf_stack_unf = r_unf;
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_SAVE)
            r_mem[w_frame][r_k] <= r_regs[r_k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    for (int i = 0; i < N; i++)
                        if (rf_data_we && rf_addr_wr == AW'(i + 2)) r_regs[i] <= rf_data_in;
                end
                ST_SAVE: begin
                    if (w_last)
                        for (int i = 0; i < N; i++) r_regs[i] <= '0;
                end
                ST_RESTORE: r_regs[r_k] <= r_mem[w_frame][r_k];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (rf_addr_r1 == AW'(1)) w_rd1 = '1;
        if (rf_addr_r2 == AW'(1)) w_rd2 = '1;
        for (int i = 0; i < N; i++) begin
            if (rf_addr_r1 == AW'(i + 2)) w_rd1 = r_regs[i];
            if (rf_addr_r2 == AW'(i + 2)) w_rd2 = r_regs[i];
        end
    end

    assign rf_data_out1 = w_rd1;
    assign rf_data_out2 = w_rd2;

    // A same-cycle write of zero to ACC is reported before it commits
    assign rf_acc_zero = (r_regs[0] == '0) ||
                         (rf_data_we && rf_addr_wr == AW'(2) && rf_data_in == '0 && r_state == ST_IDLE);
endmodule
